// File: rtl/noc_config_pkg.sv
// Network configuration and flit format shared by the router datapath blocks.
package noc_config_pkg;

    typedef struct packed {
        int unsigned virtual_channels;
    } noc_config;

    localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 2};

    localparam int FLIT_DATA_W = 8;

    typedef struct packed {
        logic                   head;
        logic                   tail;
        logic [FLIT_DATA_W-1:0] data;
    } noc_flit_t;

    localparam int FLIT_WIDTH = $bits(noc_flit_t);

    function automatic logic flit_is_head(input noc_flit_t f);
        return f.head;
    endfunction

    function automatic logic flit_is_tail(input noc_flit_t f);
        return f.tail;
    endfunction

endpackage

// File: rtl/noc_flit_bus_if.sv
// Per-channel flit bus: one valid/ready pair and one flit field per virtual channel.
interface noc_flit_bus_if #(
    parameter int CHANNELS = 2
);
    import noc_config_pkg::*;

    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    noc_flit_t           flit [CHANNELS];

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);
endinterface

// File: rtl/noc_flit_if.sv
// Shared flit link: per-channel valid/ready with a single flit field.
interface noc_flit_if #(
    parameter int CHANNELS = 2
);
    import noc_config_pkg::*;

    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    noc_flit_t           flit;

    modport initiator (output valid, output flit, input ready);
    modport target    (input valid, input flit, output ready);
endinterface

// File: rtl/noc_round_robin_arbiter.sv
// Packet-granular round-robin arbiter: a granted non-tail transfer locks the
// winner until its tail is granted, which then moves the priority pointer.
module noc_round_robin_arbiter #(
    parameter int CHANNELS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [CHANNELS-1:0] request,
    input  logic                i_lock,
    input  logic                i_free,
    output logic [CHANNELS-1:0] grant,
    output logic                o_locked
);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PTR_W-1:0]    ptr_p0;
    logic                locked_p0;
    logic [CHANNELS-1:0] lock_mask_p0;
    logic [CHANNELS-1:0] cand;
    logic [PTR_W-1:0]    grant_idx;
    logic                found;

    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int step);
        return PTR_W'((int'(base) + step) % CHANNELS);
    endfunction

    always_comb begin
        cand      = locked_p0 ? (request & lock_mask_p0) : request;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // Search starts one past the last tail owner, so that owner ranks last.
        for (int i = 1; i <= CHANNELS; i++) begin
            if (!found && i_enable && cand[rot_idx(ptr_p0, i)]) begin
                grant[rot_idx(ptr_p0, i)] = 1'b1;
                grant_idx                 = rot_idx(ptr_p0, i);
                found                     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_p0       <= PTR_W'(CHANNELS - 1);
            locked_p0    <= 1'b0;
            lock_mask_p0 <= '0;
        end else if (i_clear) begin
            ptr_p0       <= PTR_W'(CHANNELS - 1);
            locked_p0    <= 1'b0;
            lock_mask_p0 <= '0;
        end else if (found) begin
            if (i_free) begin
                locked_p0 <= 1'b0;
                ptr_p0    <= grant_idx;
            end else if (i_lock) begin
                locked_p0    <= 1'b1;
                lock_mask_p0 <= grant;
            end
        end
    end

    assign o_locked = locked_p0;

endmodule

// File: rtl/noc_vc_output_mux.sv
// Merges per-VC flit streams onto one shared link through a single output
// register, arbitrating round-robin at packet granularity.
module noc_vc_output_mux
    import noc_config_pkg::*;
#(
    parameter noc_config CONFIG = NOC_DEFAULT_CONFIG
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_clear,
    output logic [CONFIG.virtual_channels-1:0]  o_grant,
    output logic                                o_locked,
    noc_flit_bus_if.target                      flit_in_if,
    noc_flit_if.initiator                       flit_out_if
);
    localparam int CHANNELS = CONFIG.virtual_channels;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                vld_p0;
    noc_flit_t           flit_p0;
    logic [CH_W-1:0]     ch_p0;

    logic [CHANNELS-1:0] grant;
    noc_flit_t           sel_flit;
    logic [CH_W-1:0]     sel_ch;
    logic                drain;
    logic                can_load;
    logic                arb_enable;
    logic                transfer;

    assign drain      = vld_p0 & flit_out_if.ready[ch_p0];
    assign can_load   = !vld_p0 | drain;
    // Reset and clear both block acceptance so no flit is taken and then lost.
    assign arb_enable = can_load & !rst & !i_clear;
    assign transfer   = |grant;

    noc_round_robin_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (i_clear),
        .i_enable (arb_enable),
        .request  (flit_in_if.valid),
        .i_lock   (!flit_is_tail(sel_flit)),
        .i_free   (flit_is_tail(sel_flit)),
        .grant    (grant),
        .o_locked (o_locked)
    );

    always_comb begin
        sel_flit = '0;
        sel_ch   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant[c]) begin
                sel_flit = flit_in_if.flit[c];
                sel_ch   = CH_W'(c);
            end
        end
    end

    assign flit_in_if.ready = grant;

    // Stage p0: output register toward the link
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            flit_p0 <= '0;
            ch_p0   <= '0;
            o_grant <= '0;
        end else if (i_clear) begin
            vld_p0  <= 1'b0;
            flit_p0 <= '0;
            ch_p0   <= '0;
            o_grant <= '0;
        end else if (transfer) begin
            vld_p0  <= 1'b1;
            flit_p0 <= sel_flit;
            ch_p0   <= sel_ch;
            o_grant <= grant;
        end else if (drain) begin
            vld_p0  <= 1'b0;
            o_grant <= '0;
        end
    end

    always_comb begin
        flit_out_if.valid = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            flit_out_if.valid[c] = vld_p0 && (ch_p0 == CH_W'(c));
        end
    end

    assign flit_out_if.flit = flit_p0;

endmodule

// File: doc/noc_vc_output_mux.md
Name: noc_vc_output_mux

Overview:
- Output-side counterpart of the per-channel router input buffering.
- Takes one flit stream per virtual channel (a per-channel flit bus) and merges them onto one shared-flit link: per-channel valid/ready, one flit field.
- Arbitrates round-robin at packet granularity. A granted channel keeps the link until its tail flit has been taken.
- Sits between the router's per-VC output queues and the physical link to the neighbouring router's input FIFO.

Parameters:
- CONFIG, NOC_DEFAULT_CONFIG, network configuration (noc_config); supplies flit format and virtual_channels.
- CHANNELS (localparam), CONFIG.virtual_channels, number of virtual channels.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- i_clear  input  1  synchronous clear: drops the held flit, releases the lock, resets the pointer
- o_grant  output  CHANNELS  one-hot current/last owner of the link; all-zero when idle
- o_locked  output  1  a packet is in progress (head sent, tail not yet accepted at input)
- flit_in_if  noc_flit_bus_if.target  per-channel valid[CHANNELS], ready[CHANNELS], flit[CHANNELS]
- flit_out_if  noc_flit_if.initiator  valid[CHANNELS], ready[CHANNELS], shared flit

Behaviour:
- Reset (rst high, async) and i_clear (sync) give the same state:
  - flit_out_if.valid = 0, flit_out_if.flit = 0
  - o_grant = 0, o_locked = 0
  - round-robin pointer = CHANNELS-1, so channel 0 has first priority
  - flit_in_if.ready = 0 while rst is high
- Output stage: one register holding flit, channel index and valid.
  - flit_out_if.valid[ch] = stage_valid & (stage_ch == ch). At most one bit is set.
  - flit_out_if.flit = stage_flit.
  - drain = stage_valid & flit_out_if.ready[stage_ch].
  - can_load = !stage_valid | drain. This gives full throughput: 1 flit/cycle when ready is held high.
- Arbitration:
  - When not locked, candidates are all valid input channels. Priority is rotating, starting at pointer+1 mod CHANNELS.
  - When locked, the only candidate is the locked channel.
  - grant = selected candidate, only when can_load = 1; otherwise no grant.
  - flit_in_if.ready[ch] = grant[ch]. Ready is combinational from valid and state; each valid-to-ready path is same-cycle.
  - A transfer on channel g loads the stage with flit[g] and channel g.
- Locking:
  - Transferring a non-tail flit sets locked and lock_ch = g.
  - Transferring a tail flit clears locked and sets pointer = g.
  - A single-flit packet (head and tail both set) never locks.
- Latency: input handshake to flit_out_if.valid is 1 cycle.
- Stage contents are stable while valid and not drained: no flit or channel change under backpressure.
- o_grant is registered: one-hot of the channel of the last transfer. It clears when the stage empties with no new load.
- Boundary conditions:
  - Locked channel deasserts valid mid-packet (bubble): the lock is held and other channels stay blocked.
  - Downstream ready on a channel other than stage_ch has no effect.
  - Tail transfer and a new request on another channel in the same cycle: the new grant is evaluated from the next cycle with the updated pointer. The arbiter uses pre-update state, so the tail channel itself keeps the grant for this cycle.
  - Drain and load in the same cycle: the stage is overwritten with the new flit and no bubble is inserted.
  - Reset asserted mid-packet: the lock is lost and the partial packet is dropped at the output. Upstream is responsible for resynchronisation.
  - CHANNELS = 1: the block degenerates to a pipeline register; the lock logic is still present and harmless.

Decomposition:
- noc_config_pkg: noc_config, NOC_DEFAULT_CONFIG.
- noc_flit.svh: flit struct, FLIT_WIDTH, tail and head field accessors. No new typedefs.
- Sub-module noc_round_robin_arbiter:
  - Inputs: request[CHANNELS], i_free (update pointer), i_lock.
  - Output: grant[CHANNELS] one-hot.
  - Reusable by the switch allocator.

Test Plan:
- Reset, CHANNELS=2, all inputs idle:
  - During reset and after release: flit_out_if.valid=0, o_grant=0, o_locked=0, flit_in_if.ready=0.
- Ch0 sends a single-flit packet (head and tail) 0xA5, downstream ready=1:
  - ready[0]=1 in the same cycle.
  - Next cycle: valid=2'b01, flit=0xA5.
  - o_locked stays 0.
- Ch0 and ch1 both send 3-flit packets, all ready:
  - Output order: ch0 h,b,t then ch1 h,b,t.
  - valid toggles channel only after ch0's tail; no interleave; o_locked=1 during each body.
- Same as previous, but ch0 inserts a 2-cycle valid bubble after its head:
  - ch1 is not granted during the bubble.
  - ch0 resumes; ch1 starts after ch0's tail.
- Downstream ready[0]=0 for 4 cycles with a ch0 flit held:
  - flit_out_if.flit and valid are stable; flit_in_if.ready=0.
  - After ready rises: 1 flit/cycle resumes with no loss or duplication.
- Fairness with continuous single-flit traffic on ch0 and ch1:
  - Grants alternate 0,1,0,1.
  - i_clear mid-stream: next cycle valid=0 and pointer reset, so ch0 is granted first.
